serial_subtractor: RTL and testbench



---
 rtl/sersub_pkg.sv | 11 +
 rtl/serial_subtractor_fs_cell.sv | 15 +
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sersub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// The borrow function is shared by the cell and any reference model.
package sersub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sersub_state_t;

  function automatic logic fs_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_cell
  import sersub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = fs_borrow(x, y, bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, one bit per clock LSB first.
// Define SERSUB_SIGNED_OVF_EN to add the signed-overflow flag on ovf.
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sersub_state_t    state_q, state_d;
  logic [WIDTH-1:0] aSr_q, bSr_q, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q, bout_q;
  logic             cellD, cellBo;
  logic             load, lastBit;

  // A new request is taken in IDLE and also in DONE, so back-to-back runs need no gap.
  assign load    = start && (state_q != RUN);
  assign lastBit = (state_q == RUN) && (cnt_q == LAST_BIT);

  fs_cell uCell (
    .x  (aSr_q[0]),
    .y  (bSr_q[0]),
    .bi (br_q),
    .d  (cellD),
    .bo (cellBo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSr_q  <= '0;
      bSr_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (load) begin
      aSr_q <= a;
      bSr_q <= b;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      aSr_q  <= aSr_q >> 1;
      bSr_q  <= bSr_q >> 1;
      br_q   <= cellBo;
      cnt_q  <= cnt_q + CNT_W'(1);
      diff_q <= {cellD, diff_q[WIDTH-1:1]};
      if (lastBit) bout_q <= cellBo;
    end
  end

`ifdef SERSUB_SIGNED_OVF_EN
  logic brMsb_q;

  // The borrow entering the MSB differs from the one leaving it exactly on signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       brMsb_q <= 1'b0;
    else if (lastBit) brMsb_q <= br_q;
  end

  assign ovf = brMsb_q ^ bout_q;
`else
  assign ovf = 1'b0;
`endif

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): arithmetic model, randomized sweep.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int               accEdge;
  } expect_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy, done, bout, ovf;
  logic [WIDTH-1:0] diff;

  logic cx = 1'b0, cy = 1'b0, cbi = 1'b0;
  logic cd, cbo;

  int checks = 0;
  int failures = 0;
  int edgeCount = 0;
  int busyCount = 0;
  logic prevDone = 1'b0;
  expect_t expQ[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  fs_cell goldenCell (.x(cx), .y(cy), .bi(cbi), .d(cd), .bo(cbo));

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic expect_t modelOf(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                      input logic mbin);
    expect_t e;
    int ua, ub, sa, sb, r;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    e.diff = WIDTH'((ua - ub - int'(mbin)) & 255);
    e.bout = (ua < ub + int'(mbin));
    r = sa - sb - int'(mbin);
`ifdef SERSUB_SIGNED_OVF_EN
    e.ovf = (r < -128) || (r > 127);
`else
    e.ovf = 1'b0;
    if (r == 0) e.ovf = 1'b0;
`endif
    e.accEdge = 0;
    return e;
  endfunction

  function automatic void pushExpect(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                     input logic mbin);
    expect_t e;
    e = modelOf(ma, mb, mbin);
    e.accEdge = edgeCount + 1;
    expQ.push_back(e);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst_n) begin
      busyCount = 0;
      prevDone = 1'b0;
    end else begin
      if (busy) busyCount++;
      if (done) begin
        expect_t e;
        if (prevDone) checkOutput("done_width", 64'(prevDone), 64'(0));
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput("diff", 64'(diff), 64'(e.diff));
          checkOutput("bout", 64'(bout), 64'(e.bout));
          checkOutput("ovf", 64'(ovf), 64'(e.ovf));
          checkOutput("latency", 64'(edgeCount - e.accEdge), 64'(WIDTH));
          checkOutput("busy_cycles", 64'(busyCount), 64'(WIDTH));
        end
        busyCount = 0;
      end
      prevDone = done;
    end
  end

  task automatic waitNotBusy();
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("timeout_busy", 64'(busy), 64'(0));
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                               input logic sbin);
    @(negedge clk);
    waitNotBusy();
    start = 1'b1;
    a = sa;
    b = sb;
    bin = sbin;
    pushExpect(sa, sb, sbin);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (expQ.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_pending", 64'(expQ.size()), 64'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_diff"}, 64'(diff), 64'(0));
    checkOutput({tag, "_bout"}, 64'(bout), 64'(0));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(0));
  endtask

  initial begin
    int r;
    #3;
    checkAllZero("reset");

    // Golden cell against integer arithmetic for all eight input combinations.
    for (int i = 0; i < 8; i++) begin
      {cx, cy, cbi} = 3'(i);
      #1;
      r = int'(cx) - int'(cy) - int'(cbi);
      checkOutput("cell_d", 64'(cd), 64'(r & 1));
      checkOutput("cell_bo", 64'(cbo), 64'(r < 0));
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h05, 8'h03, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0);
    applyStimulus(8'h10, 8'h0F, 1'b1);
    applyStimulus(8'h22, 8'h22, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b1);
    applyStimulus(8'h80, 8'h01, 1'b0);
    applyStimulus(8'h7F, 8'hFF, 1'b0);
    applyStimulus(8'h03, 8'h01, 1'b0);
    drain();

    // start re-pulsed mid-run with other operands must not disturb the result.
    applyStimulus(8'h3C, 8'h19, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held high through DONE: second run begins with no IDLE cycle.
    @(negedge clk);
    start = 1'b1; a = 8'h9A; b = 8'h3B; bin = 1'b1;
    pushExpect(8'h9A, 8'h3B, 1'b1);
    @(negedge clk);
    a = 8'h01; b = 8'hC0; bin = 1'b0;
    waitNotBusy();
    pushExpect(8'h01, 8'hC0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-run aborts with no done pulse.
    applyStimulus(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkAllZero("abort");
    repeat (3) @(negedge clk);
    checkOutput("abort_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    applyStimulus(8'hAA, 8'h55, 1'b0);
    drain();

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
